// File: rtl/icache_refill_engine.sv
// icache_refill_engine: fetches one L1I block as BEATS memory beats,
// then writes the assembled block into the cache with a one-cycle pulse.
module icache_refill_engine #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int BEAT_W  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                miss_i,
  input  logic [ADDR_W-1:0]   missAddr_i,
  output logic                memReqValid_o,
  output logic [ADDR_W-1:0]   memReqAddr_o,
  input  logic                memReqReady_i,
  input  logic                memRespValid_i,
  input  logic [BEAT_W-1:0]   memRespData_i,
  output logic                wrEnable_o,
  output logic [ADDR_W-1:0]   wrAddr_o,
  output logic [BLOCK_W-1:0]  instBlock_o,
  output logic                busy_o,
  output logic [15:0]         refillCount_o
);

  localparam int BEATS  = BLOCK_W / BEAT_W;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_B = BEAT_W / 8;
  localparam logic [ADDR_W-1:0] BLK_MASK =
    ~ADDR_W'(BLOCK_W / 8 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WRITE,
    S_SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   block_addr_q, block_addr_d;
  logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         refill_count_q, refill_count_d;
  logic                req_valid;
  logic                wr_en;

  // State register; reset abandons any refill in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      block_addr_q   <= '0;
      beat_idx_q     <= '0;
      block_q        <= '0;
      wr_addr_q      <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      block_addr_q   <= block_addr_d;
      beat_idx_q     <= beat_idx_d;
      block_q        <= block_d;
      wr_addr_q      <= wr_addr_d;
      refill_count_q <= refill_count_d;
    end
  end

  // Next-state, beat capture and handshake outputs.
  always_comb begin
    state_d        = state_q;
    block_addr_d   = block_addr_q;
    beat_idx_d     = beat_idx_q;
    block_d        = block_q;
    wr_addr_d      = wr_addr_q;
    refill_count_d = refill_count_q;
    req_valid      = 1'b0;
    wr_en          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          block_addr_d = missAddr_i & BLK_MASK;
          beat_idx_d   = '0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        req_valid = 1'b1;
        if (memReqReady_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (memRespValid_i) begin
          block_d[int'(beat_idx_q)*BEAT_W +: BEAT_W] = memRespData_i;
          if (beat_idx_q == LAST_IDX) begin
            wr_addr_d = block_addr_q;
            state_d   = S_WRITE;
          end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
            state_d    = S_REQ;
          end
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (refill_count_q != 16'hFFFF) begin
          refill_count_d = refill_count_q + 16'd1;
        end
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign memReqValid_o = req_valid;
  assign memReqAddr_o  = block_addr_q
                       + ADDR_W'(beat_idx_q) * ADDR_W'(BEAT_B);
  assign wrEnable_o    = wr_en;
  assign wrAddr_o      = wr_addr_q;
  assign instBlock_o   = block_q;
  assign busy_o        = (state_q != S_IDLE);
  assign refillCount_o = refill_count_q;

endmodule

// File: tb/tb_icache_refill_engine.sv
// tb_icache_refill_engine: directed refill scenarios with
// hand-computed addresses, block contents, latency and counts.
module tb_icache_refill_engine;

  logic         clk;
  logic         reset;
  logic         miss_i;
  logic [31:0]  missAddr_i;
  logic         memReqValid_o;
  logic [31:0]  memReqAddr_o;
  logic         memReqReady_i;
  logic         memRespValid_i;
  logic [63:0]  memRespData_i;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         busy_o;
  logic [15:0]  refillCount_o;

  int n_cmp = 0;
  int n_bad = 0;

  icache_refill_engine dut (
    .clk            (clk),
    .reset          (reset),
    .miss_i         (miss_i),
    .missAddr_i     (missAddr_i),
    .memReqValid_o  (memReqValid_o),
    .memReqAddr_o   (memReqAddr_o),
    .memReqReady_i  (memReqReady_i),
    .memRespValid_i (memRespValid_i),
    .memRespData_i  (memRespData_i),
    .wrEnable_o     (wrEnable_o),
    .wrAddr_o       (wrAddr_o),
    .instBlock_o    (instBlock_o),
    .busy_o         (busy_o),
    .refillCount_o  (refillCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_blk(input logic [63:0] base);
    logic [255:0] r;
    for (int b = 0; b < 4; b++) r[b*64 +: 64] = base + 64'(b);
    return r;
  endfunction

  // One refill; responses arrive the cycle after each accept.
  task automatic refill(input string tag,
                        input logic [31:0] ma,
                        input logic [31:0] blk,
                        input logic [63:0] base,
                        input int stall_b,
                        input int stall_n,
                        input bit spur,
                        input bit redir,
                        input int abort_at,
                        input logic [15:0] cnt);
    int cyc;
    logic [31:0] ra;
    cyc = 0;
    miss_i = 1'b1;
    missAddr_i = ma;
    memReqReady_i = 1'b1;
    memRespValid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); cyc++;
      memRespValid_i = 1'b0;
      if (!redir) miss_i = 1'b0;
      if (b == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk({tag, "_rst_busy"}, busy_o, 0);
        chk({tag, "_rst_wr"}, wrEnable_o, 0);
        chk({tag, "_rst_cnt"}, refillCount_o, 0);
        chk({tag, "_rst_blk"}, instBlock_o, 0);
        chk({tag, "_rst_val"}, memReqValid_o, 0);
        memRespValid_i = 1'b1;
        memRespData_i = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        memRespValid_i = 1'b0;
        chk({tag, "_late_busy"}, busy_o, 0);
        chk({tag, "_late_blk"}, instBlock_o, 0);
        chk({tag, "_late_wr"}, wrEnable_o, 0);
        return;
      end
      if (redir && b == 1) missAddr_i = 32'h0000_4000;
      ra = blk + 32'(8 * b);
      chk({tag, "_reqv"}, memReqValid_o, 1);
      chk({tag, "_reqa"}, memReqAddr_o, ra);
      if (b == stall_b) begin
        memReqReady_i = 1'b0;
        if (spur) begin
          memRespValid_i = 1'b1;
          memRespData_i = 64'hDEAD_BEEF_0BAD_F00D;
        end
        repeat (stall_n) begin
          @(negedge clk); cyc++;
          chk({tag, "_holdv"}, memReqValid_o, 1);
          chk({tag, "_holda"}, memReqAddr_o, ra);
        end
        memRespValid_i = 1'b0;
        memReqReady_i = 1'b1;
      end
      @(negedge clk); cyc++;
      chk({tag, "_respv"}, memReqValid_o, 0);
      memRespValid_i = 1'b1;
      memRespData_i = base + 64'(b);
    end
    @(negedge clk); cyc++;
    memRespValid_i = 1'b0;
    chk({tag, "_lat"}, 32'(cyc), 32'(9 + stall_n));
    chk({tag, "_wren"}, wrEnable_o, 1);
    chk({tag, "_wra"}, wrAddr_o, blk);
    chk({tag, "_blk"}, instBlock_o, mk_blk(base));
    @(negedge clk);
    chk({tag, "_wr1"}, wrEnable_o, 0);
    chk({tag, "_stl"}, busy_o, 1);
    chk({tag, "_cnt"}, refillCount_o, cnt);
    chk({tag, "_wrah"}, wrAddr_o, blk);
    @(negedge clk);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_idlv"}, memReqValid_o, 0);
    chk({tag, "_blkh"}, instBlock_o, mk_blk(base));
  endtask

  initial begin
    reset = 1'b1;
    miss_i = 1'b0;
    missAddr_i = '0;
    memReqReady_i = 1'b0;
    memRespValid_i = 1'b0;
    memRespData_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_val", memReqValid_o, 0);
    chk("rst_wr", wrEnable_o, 0);
    chk("rst_cnt", refillCount_o, 0);
    chk("rst_wra", wrAddr_o, 0);
    chk("rst_blk", instBlock_o, 0);
    chk("rst_reqa", memReqAddr_o, 0);
    reset = 1'b0;

    refill("basic", 32'h0000_1234, 32'h0000_1220, 64'hA,
           -1, 0, 1'b0, 1'b0, -1, 16'd1);
    chk("basic_const", instBlock_o,
        {64'hD, 64'hC, 64'hB, 64'hA});

    refill("bp", 32'h0000_1234, 32'h0000_1220, 64'h10,
           2, 3, 1'b0, 1'b0, -1, 16'd2);

    refill("redir", 32'h0000_1234, 32'h0000_1220, 64'h20,
           -1, 0, 1'b0, 1'b1, -1, 16'd3);
    refill("newblk", 32'h0000_4000, 32'h0000_4000, 64'h30,
           -1, 0, 1'b0, 1'b0, -1, 16'd4);

    memRespValid_i = 1'b1;
    memRespData_i = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    memRespValid_i = 1'b0;
    chk("spur_idle_busy", busy_o, 0);
    chk("spur_idle_blk", instBlock_o, mk_blk(64'h30));

    refill("spur_req", 32'h0000_2004, 32'h0000_2000, 64'h40,
           0, 2, 1'b1, 1'b0, -1, 16'd5);

    refill("abort", 32'h0000_1234, 32'h0000_1220, 64'h48,
           -1, 0, 1'b0, 1'b0, 3, 16'd0);
    refill("clean", 32'h0000_1234, 32'h0000_1220, 64'h50,
           -1, 0, 1'b0, 1'b0, -1, 16'd1);

    refill("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFE0, 64'h60,
           -1, 0, 1'b0, 1'b0, -1, 16'd2);

    force dut.refill_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.refill_count_q;
    @(negedge clk);
    chk("sat_pre", refillCount_o, 16'hFFFF);
    refill("sat", 32'h0000_0100, 32'h0000_0100, 64'h70,
           -1, 0, 1'b0, 1'b0, -1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_engine.md
ICACHE_REFILL_ENGINE -- requirements
Module: icache_refill_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/address width.
REQ-002 SHALL have parameter BLOCK_W, default 256, refill block width in bits (32 bytes).
REQ-003 SHALL have parameter BEAT_W, default 64, memory data beat width; BEATS = BLOCK_W/BEAT_W (default 4).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 miss_i  input  1  fetch-stage L1I miss indication (level).
REQ-007 missAddr_i  input  ADDR_W  missing fetch address; may be unaligned.
REQ-008 memReqValid_o  output  1  memory read request valid.
REQ-009 memReqAddr_o  output  ADDR_W  beat byte address, BEAT_W/8-aligned.
REQ-010 memReqReady_i  input  1  memory accepts request when high with memReqValid_o.
REQ-011 memRespValid_i  input  1  one returned beat valid.
REQ-012 memRespData_i  input  BEAT_W  returned beat data.
REQ-013 wrEnable_o  output  1  one-cycle cache write pulse.
REQ-014 wrAddr_o  output  ADDR_W  block-aligned write address.
REQ-015 instBlock_o  output  BLOCK_W  assembled refill block.
REQ-016 busy_o  output  1  high in any state except IDLE.
REQ-017 refillCount_o  output  16  completed refills, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RESP, WRITE, SETTLE.
REQ-019 IDLE: on miss_i=1, SHALL latch blockAddr = missAddr_i with low log2(BLOCK_W/8) bits cleared, clear beat index to 0, go to REQ next cycle.
REQ-020 REQ: SHALL drive memReqValid_o=1, memReqAddr_o = blockAddr + beatIdx*(BEAT_W/8); hold both stable until memReqReady_i=1; then go to RESP.
REQ-021 At most one request SHALL be outstanding; memReqValid_o SHALL be 0 outside REQ.
REQ-022 RESP: on memRespValid_i=1, SHALL store memRespData_i into instBlock_o[beatIdx*BEAT_W +: BEAT_W]; if beatIdx = BEATS-1 go to WRITE, else increment beatIdx and go to REQ.
REQ-023 memRespValid_i outside RESP SHALL be ignored (no state or data change).
REQ-024 WRITE: SHALL assert wrEnable_o=1 for exactly one cycle with wrAddr_o=blockAddr and complete instBlock_o, increment refillCount_o (saturating), go to SETTLE.
REQ-025 SETTLE: SHALL ignore miss_i for one cycle (cache lookup re-evaluates), then return to IDLE.
REQ-026 wrAddr_o and instBlock_o SHALL hold last written values until the next refill overwrites beats.
REQ-027 Changes of miss_i/missAddr_i after latch (redirect, flush) SHALL NOT abort a refill; the block completes and is written for the latched address.
REQ-028 Minimum latency miss_i to wrEnable_o with ready/resp always 1 in the cycle after request: 1 + 2*BEATS cycles (9 at default).
REQ-029 blockAddr arithmetic SHALL be ADDR_W bits, wrapping modulo 2^ADDR_W.

Reset
REQ-030 On reset, SHALL enter IDLE, beatIdx=0, memReqValid_o=0, wrEnable_o=0, busy_o=0, refillCount_o=0, wrAddr_o=0, instBlock_o=0, memReqAddr_o=0.
REQ-031 Reset asserted mid-refill SHALL abandon the refill next edge with no wrEnable_o pulse; later late memRespValid_i SHALL be ignored per REQ-023.

Verification
REQ-032 Basic: missAddr_i=0x0000_1234, ready=1, each resp one cycle after accept with data 0xA..0xD -> req addrs 0x1220,0x1228,0x1230,0x1238; wrEnable_o pulse at cycle 9 with wrAddr_o=0x1220, instBlock_o={D,C,B,A}; refillCount_o=1.
REQ-033 Backpressure: memReqReady_i low 3 cycles on beat 2 -> memReqAddr_o=0x1230 held stable, memReqValid_o held, block still correct.
REQ-034 Redirect: missAddr_i changes to 0x4000 during beat 1 -> refill completes to 0x1220; after SETTLE, new refill starts at 0x4000.
REQ-035 Spurious response: memRespValid_i=1 in IDLE and REQ -> no data capture, no state change.
REQ-036 Reset mid-refill after beat 2 -> IDLE, no wrEnable_o, refillCount_o=0; next miss refills cleanly.
REQ-037 Wrap: missAddr_i=0xFFFF_FFF8 -> blockAddr 0xFFFF_FFE0, last beat addr 0xFFFF_FFF8, no overflow artifacts; counter saturation checked by preload-forcing 0xFFFF -> stays 0xFFFF.
